// File: rtl/multi_mode_shift_unit_pkg.sv
// ---------------------------------------------------------------------------
// multi_mode_shift_unit_pkg
//   Shared encodings for the multi-cycle shifter/rotator and its step shifter.
//   Contents:
//     mode_e    : operating modes as presented on the 'mode' input
//     ST_*      : FSM state constants (IDLE -> RUN -> DONE -> IDLE)
//     is_rotate : true for both rotate encodings (0 and its alias 3)
// ---------------------------------------------------------------------------
package multi_mode_shift_unit_pkg;

    // Operating modes. Encoding 3 is an alias of plain rotation.
    typedef enum logic [1:0] {
        MODE_ROT     = 2'd0,   // true rotation, vacated bits take wrapped bits
        MODE_SHF     = 2'd1,   // logical shift, vacated bits take latched cin
        MODE_ARI     = 2'd2,   // arithmetic: right fills with MSB, left fills 0
        MODE_ROT_ALT = 2'd3    // rotation alias
    } mode_e;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Both rotate encodings behave identically.
    function automatic logic is_rotate(input logic [1:0] m);
        return (m == MODE_ROT) || (m == MODE_ROT_ALT);
    endfunction

endpackage

// File: rtl/multi_mode_shift_unit_step_shifter.sv
// ---------------------------------------------------------------------------
// multi_mode_shift_unit_step_shifter
//   Purely combinational single-step mover. Moves 'data' by 's' bit positions
//   (0..N) in direction 'dir'. Rotate modes refill vacated positions with the
//   bits pushed out of the other end; all other modes refill with 'fill'.
//   Ports:
//     data   in  N      word to move
//     s      in  AMT_W  number of positions to move this step (<= N)
//     mode   in  2      operating mode (see mode_e)
//     dir    in  1      1 = toward MSB, 0 = toward LSB
//     fill   in  1      fill bit for non-rotate modes
//     result out N      moved word
// ---------------------------------------------------------------------------
module multi_mode_shift_unit_step_shifter
    import multi_mode_shift_unit_pkg::*;
#(
    parameter int N     = 25,
    parameter int AMT_W = 8
) (
    input  logic [N-1:0]     data,
    input  logic [AMT_W-1:0] s,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             fill,
    output logic [N-1:0]     result
);

    // The word that supplies the vacated positions: a copy of the data itself
    // for rotation (so wrapped bits re-enter), otherwise a replicated fill bit.
    logic [N-1:0] fill_word;
    logic [N-1:0] left_res;
    logic [N-1:0] right_res;

    assign fill_word = is_rotate(mode) ? data : {N{fill}};

    // Double-width trick: place the fill word next to the data on the side the
    // bits enter from, shift the 2N-bit pair, and keep the data-aligned half.
    // Works for any s in 0..N, which covers every step the top level issues.
    assign left_res  = N'(({data, fill_word} << s) >> N);
    assign right_res = N'({fill_word, data} >> s);

    assign result = dir ? left_res : right_res;

endmodule

// File: rtl/multi_mode_shift_unit.sv
// ---------------------------------------------------------------------------
// multi_mode_shift_unit
//   Multi-cycle word shifter/rotator. A word is loaded on an accepted start,
//   then moved by 'amount' positions, at most STEP positions per RUN cycle,
//   followed by a one-cycle done pulse. Abort cancels an operation in flight
//   and leaves the partially moved word on dout.
//   Ports:
//     clk    in  1      clock, rising edge
//     rst    in  1      asynchronous active-low reset
//     start  in  1      request, sampled only in IDLE
//     abort  in  1      synchronous cancel (wins over start in IDLE)
//     mode   in  2      0 rotate, 1 shift with cin fill, 2 arithmetic, 3 rotate
//     dir    in  1      1 = left (toward MSB), 0 = right
//     amount in  AMT_W  total positions to move
//     cin    in  1      fill bit for mode 1
//     din    in  N      operand word
//     busy   out 1      high in RUN and DONE
//     done   out 1      one-cycle pulse, dout valid
//     dout   out N      data register, always driven
// ---------------------------------------------------------------------------
module multi_mode_shift_unit
    import multi_mode_shift_unit_pkg::*;
#(
    parameter int N     = 25,
    parameter int STEP  = 1,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [AMT_W-1:0] amount,
    input  logic             cin,
    input  logic [N-1:0]     din,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     dout
);

    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    // State and datapath registers.
    logic [1:0]       state_reg, state_next;
    logic [N-1:0]     data_reg,  data_next;
    logic [AMT_W-1:0] rem_reg,   rem_next;

    // Controls captured at start so input changes during busy have no effect.
    logic [1:0]       mode_reg,  mode_next;
    logic             dir_reg,   dir_next;
    logic             cin_reg,   cin_next;

    logic [AMT_W-1:0] step_amt;
    logic             fill_bit;
    logic [N-1:0]     stepped;

    // Positions moved this cycle: never more than what remains, so the
    // remaining count cannot underflow.
    assign step_amt = (rem_reg > STEP_AMT) ? STEP_AMT : rem_reg;

    // Fill bit for non-rotate modes. Arithmetic right replicates the current
    // MSB on every step, which yields sign extension across multi-bit steps.
    always_comb begin
        fill_bit = 1'b0;
        case (mode_reg)
            MODE_SHF: fill_bit = cin_reg;
            MODE_ARI: fill_bit = dir_reg ? 1'b0 : data_reg[N-1];
            default:  fill_bit = 1'b0;
        endcase
    end

    multi_mode_shift_unit_step_shifter #(
        .N     (N),
        .AMT_W (AMT_W)
    ) u_step_shifter (
        .data   (data_reg),
        .s      (step_amt),
        .mode   (mode_reg),
        .dir    (dir_reg),
        .fill   (fill_bit),
        .result (stepped)
    );

    // Next-state and datapath logic.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rem_next   = rem_reg;
        mode_next  = mode_reg;
        dir_next   = dir_reg;
        cin_next   = cin_reg;

        case (state_reg)
            ST_IDLE: begin
                // Abort has priority: a simultaneous start loads nothing.
                if (start && !abort) begin
                    data_next  = din;
                    rem_next   = amount;
                    mode_next  = mode;
                    dir_next   = dir;
                    cin_next   = cin;
                    state_next = (amount == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Partially moved word stays visible on dout.
                    rem_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    data_next = stepped;
                    rem_next  = rem_reg - step_amt;
                    if (rem_reg <= STEP_AMT) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Single-cycle state; abort here simply takes the same exit.
                rem_next   = '0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                rem_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            rem_reg   <= '0;
            mode_reg  <= '0;
            dir_reg   <= 1'b0;
            cin_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rem_reg   <= rem_next;
            mode_reg  <= mode_next;
            dir_reg   <= dir_next;
            cin_reg   <= cin_next;
        end
    end

    assign busy = (state_reg == ST_RUN) || (state_reg == ST_DONE);
    assign done = (state_reg == ST_DONE);
    assign dout = data_reg;

endmodule

// File: tb/tb_multi_mode_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_multi_mode_shift_unit
//   Two instances (STEP=1 and STEP=4) share one stimulus stream. Each issued
//   operation pushes the expected word and latency onto a per-instance queue;
//   a monitor per instance pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_multi_mode_shift_unit;

    localparam int N     = 25;
    localparam int AMT_W = 8;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic             start  = 1'b0;
    logic             abort  = 1'b0;
    logic [1:0]       mode   = 2'd0;
    logic             dir    = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic             cin    = 1'b0;
    logic [N-1:0]     din    = '0;

    logic             busy1, done1, busy4, done4;
    logic [N-1:0]     dout1, dout4;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        logic [N-1:0] dout;
        int           issue;
        int           lat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;

    multi_mode_shift_unit #(.N(N), .STEP(1), .AMT_W(AMT_W)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .dir(dir), .amount(amount), .cin(cin), .din(din),
        .busy(busy1), .done(done1), .dout(dout1)
    );

    multi_mode_shift_unit #(.N(N), .STEP(4), .AMT_W(AMT_W)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .dir(dir), .amount(amount), .cin(cin), .din(din),
        .busy(busy4), .done(done4), .dout(dout4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: apply 'a' single-position moves following the fill rules.
    function automatic logic [N-1:0] model(input logic [1:0] m, input logic d,
                                           input logic [AMT_W-1:0] a, input logic c,
                                           input logic [N-1:0] x);
        logic [N-1:0] w;
        w = x;
        for (int i = 0; i < int'(a); i++) begin
            if (m == 2'd0 || m == 2'd3)
                w = d ? {w[N-2:0], w[N-1]} : {w[0], w[N-1:1]};
            else if (m == 2'd1)
                w = d ? {w[N-2:0], c} : {c, w[N-1:1]};
            else
                w = d ? {w[N-2:0], 1'b0} : {w[N-1], w[N-1:1]};
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitors: compare dout and start-to-done latency on each done pulse.
    always @(negedge clk) begin
        if (rst && done1) begin
            if (q1.size() == 0) begin
                total_cnt++;
                $display("FAIL dut1_spurious_done: got done=1, required no done (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1_dout", 32'(dout1), 32'(e1.dout));
                check("dut1_latency", 32'(cyc - e1.issue), 32'(e1.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && done4) begin
            if (q4.size() == 0) begin
                total_cnt++;
                $display("FAIL dut4_spurious_done: got done=1, required no done (cycle %0d)", cyc);
            end else begin
                e4 = q4.pop_front();
                check("dut4_dout", 32'(dout4), 32'(e4.dout));
                check("dut4_latency", 32'(cyc - e4.issue), 32'(e4.lat));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy1 || busy4) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (busy1 || busy4) begin
            total_cnt++;
            $display("FAIL wait_idle: got busy1=%0b busy4=%0b, required idle", busy1, busy4);
        end
    endtask

    // Issue one operation at a negedge while both instances are idle. The
    // cycle after the start edge drives random controls and a stray start,
    // both of which must be ignored while busy.
    task automatic issue(input logic [1:0] m, input logic d, input logic [AMT_W-1:0] a,
                         input logic c, input logic [N-1:0] x);
        exp_t e;
        mode = m; dir = d; amount = a; cin = c; din = x; start = 1'b1;
        e.dout  = model(m, d, a, c, x);
        e.issue = cyc;
        e.lat   = (a == '0) ? 1 : int'(a) + 1;
        q1.push_back(e);
        e.lat   = (int'(a) + 3) / 4 + 1;
        q4.push_back(e);
        $display("txn mode=%0d dir=%0d amount=%0d cin=%0b din=%07h expect=%07h",
                 m, d, a, c, x, e.dout);
        @(negedge clk);
        start  = 1'($urandom_range(0, 1));
        mode   = 2'($urandom_range(0, 3));
        dir    = 1'($urandom_range(0, 1));
        cin    = 1'($urandom_range(0, 1));
        amount = AMT_W'($urandom);
        din    = N'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [1:0]       m;
        logic             d, c;
        logic [AMT_W-1:0] a;
        logic [N-1:0]     x;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_dout1", 32'(dout1), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_dout4", 32'(dout4), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases.
        issue(2'd0, 1'b1, 8'd3,  1'b0, 25'h0000001); wait_idle();
        issue(2'd0, 1'b0, 8'd5,  1'b0, 25'h0000001); wait_idle();
        issue(2'd1, 1'b1, 8'd4,  1'b1, 25'h0000000); wait_idle();
        issue(2'd2, 1'b0, 8'd2,  1'b0, 25'h1000000); wait_idle();
        issue(2'd0, 1'b1, 8'd0,  1'b0, 25'h1234567); wait_idle();
        issue(2'd1, 1'b1, 8'd30, 1'b0, 25'h1FFFFFF); wait_idle();
        issue(2'd3, 1'b0, 8'd27, 1'b0, 25'h0ABCDEF); wait_idle();
        issue(2'd2, 1'b0, 8'd40, 1'b0, 25'h1800000); wait_idle();

        // Abort at the 4th RUN edge of the STEP=1 instance; the STEP=4
        // instance has already finished and pulses done normally.
        x = N'($urandom);
        m = 2'($urandom_range(0, 3));
        d = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        mode = m; dir = d; cin = c; din = x; amount = 8'd10; start = 1'b1;
        e4.dout = model(m, d, 8'd10, c, x);
        e4.issue = cyc;
        e4.lat = 4;
        q4.push_back(e4);
        $display("txn abort mode=%0d dir=%0d amount=10 cin=%0b din=%07h expect=%07h",
                 m, d, c, x, model(m, d, 8'd3, c, x));
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_dout1", 32'(dout1), 32'(model(m, d, 8'd3, c, x)));
        check("abort_busy1", 32'(busy1), 32'd0);
        wait_idle();
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        issue(2'd1, 1'b1, 8'd20, 1'b1, N'($urandom) | 25'h1);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy1", 32'(busy1), 32'd0);
        check("midrst_done1", 32'(done1), 32'd0);
        check("midrst_dout1", 32'(dout1), 32'd0);
        check("midrst_busy4", 32'(busy4), 32'd0);
        check("midrst_done4", 32'(done4), 32'd0);
        check("midrst_dout4", 32'(dout4), 32'd0);
        q1.delete();
        q4.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Start together with abort in IDLE loads nothing.
        $display("txn start+abort in idle");
        start = 1'b1; abort = 1'b1; din = N'($urandom) | 25'h1; amount = 8'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("sa_busy1", 32'(busy1), 32'd0);
        check("sa_busy4", 32'(busy4), 32'd0);
        check("sa_dout1", 32'(dout1), 32'd0);
        check("sa_dout4", 32'(dout4), 32'd0);
        repeat (3) @(negedge clk);

        // Randomised operations.
        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            x = N'($urandom);
            a = (i % 8 == 0) ? AMT_W'($urandom_range(0, 255)) : AMT_W'($urandom_range(0, 40));
            issue(m, d, a, c, x);
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check("pending_q1", 32'(q1.size()), 32'd0);
        check("pending_q4", 32'(q4.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
